key_entry_accumulator: RTL
==========================

# key_entry_accumulator

Consumes the scanned key code from the keyboard controller (`BCDKey`, `KeyRead`) and turns raw key presses into calculator operands. Each press is debounced and accepted exactly once, and digits are shifted into a 4-digit BCD operand. When an operator key is pressed, the finished operand and its operator are handed to the arithmetic stage over a valid/ready handshake. It also drives the live entry value for the display path.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to accept or release a key; legal range ≥1.
- `CLK` in 1: system clock; all state changes on rising edge.
- `RESET` in 1: reset; synchronous, active-low.
- `BCDKey` in 4: key code from the keyboard controller; valid only while `KeyRead`=1.
- `KeyRead` in 1: high while a key is held.
- `OpReady` in 1: downstream ready to take the operand/operator pair.
- `OpValid` out 1: operand/operator pair is valid.
- `Operand` out 16: 4-digit BCD operand; [15:12] is the most significant digit.
- `OpCode` out 4: operator key code accompanying `Operand`.
- `EntryValue` out 16: live BCD entry for the display.
- `DigitCount` out 3: digits currently entered, 0..4.
- `Overflow` out 1: sticky; a 5th digit was attempted.

## Operation
- Inputs are registered once (`kr_q`, `key_q`) before any use.
- Key map:
  - 0x0–0x9: digits.
  - 0xA add, 0xB sub, 0xC mul, 0xF equals: operators.
  - 0xD: backspace.
  - 0xE: clear entry.
- Debounce FSM states:
  - IDLE: `kr_q`=1 → go to PRESS; capture `key_q`; stable counter = 1.
  - PRESS: counter increments while `kr_q`=1 and `key_q` equals the captured code. If `kr_q`=0 or the code differs, return to IDLE. When the counter reaches `DEBOUNCE_CYCLES`, accept the captured code (1-cycle internal strobe) → HELD.
  - HELD: wait for `kr_q`=0 → RELEASE with counter = 1. A code change while held is ignored.
  - RELEASE: counter increments while `kr_q`=0. If `kr_q`=1, return to HELD. When the counter reaches `DEBOUNCE_CYCLES` → IDLE.
- Actions on an accepted key:
  - Digit, `DigitCount`<4: `EntryValue` <= {`EntryValue`[11:0], key}; count+1.
  - Digit, `DigitCount`=4: entry unchanged; `Overflow` <= 1.
  - Backspace: `EntryValue` <= `EntryValue`>>4; count−1. At count 0, no change.
  - Clear: `EntryValue`=0, count=0, `Overflow`=0.
  - Operator: `Operand` <= `EntryValue`; `OpCode` <= key; `OpValid` <= 1. Entry is cleared the same edge (`EntryValue`=0, count=0, `Overflow`=0). An operator with count 0 sends operand 0x0000.
- Handshake:
  - `OpValid`, `Operand` and `OpCode` hold stable until a cycle where `OpValid`=1 and `OpReady`=1.
  - `OpValid` drops on the following edge.
- Any key accepted while `OpValid`=1 is discarded with no state change. Debounce still runs, so the key counts as consumed.

## Timing
- Reset values (on a rising edge with `RESET`=0): all outputs 0; FSM in IDLE; counters 0. Reset mid-press discards the key. A key still held after reset must be released and pressed again? No: it is re-debounced from IDLE.
- Latency: `KeyRead`=1 with a constant code sampled at edge k → `kr_q`=1 after edge k → FSM reaches PRESS at edge k+1 → accept strobe after edge k+`DEBOUNCE_CYCLES` → `EntryValue`/`OpValid` updated at edge k+`DEBOUNCE_CYCLES`+1.
- `OpValid` may go high with `OpReady` already 1. Transfer then completes that cycle, and `OpValid` is low one edge later (minimum pulse of 1 cycle).
- Simultaneous accept and handshake completion in the same cycle: the accept is discarded, because `OpValid` is still 1.
- Glitches: a `KeyRead` pulse shorter than `DEBOUNCE_CYCLES` samples is never accepted. A release gap shorter than `DEBOUNCE_CYCLES` does not produce a second accept.

## Test plan
- Reset with `RESET`=0 for 2 cycles → all outputs 0. Press 0x7 for 10 cycles (`DEBOUNCE_CYCLES`=4) → `EntryValue`=0x0007 exactly 5 edges after the first sample; `DigitCount`=1.
- Press 1,2,3,4,5 (each held 8 cycles, gaps of 8) → `EntryValue`=0x1234, `DigitCount`=4, `Overflow`=1. Then press 0xD → 0x0123, count 3. Then press 0xE → 0x0000, `Overflow`=0.
- Press 4, 2, then 0xA with `OpReady`=0 → `OpValid`=1, `Operand`=0x0042, `OpCode`=0xA, all held stable for 20 cycles. Raise `OpReady` → `OpValid` low next edge; `EntryValue`=0.
- Bounce: `KeyRead` toggles 1,0,1,1,0 then holds 1 with code 0x3 → exactly one accept. A 2-cycle release gap inside the hold → no second digit.
- While `OpValid`=1, press 0x9 → ignored; after the handshake, `EntryValue`=0x0000.
- Drive `RESET`=0 during the PRESS state of key 0x5 → no digit entered. The key remains held afterwards → accepted once after a fresh debounce.

Source files
------------

// File: rtl/key_entry_accumulator.sv
`timescale 1ns/1ps
// key_entry_accumulator
//   Turns raw keyboard-controller key codes into calculator operands.
//   Every press is debounced and accepted once. Digits are shifted into a
//   4-digit BCD entry. An operator key hands the finished operand and its
//   operator to the arithmetic stage over a valid/ready handshake.
//
// Ports
//   CLK        : system clock, rising edge
//   RESET      : synchronous, active-low reset
//   BCDKey     : key code, meaningful only while KeyRead=1
//   KeyRead    : high while a key is held
//   OpReady    : downstream can take the operand/operator pair
//   OpValid    : operand/operator pair valid
//   Operand    : 4-digit BCD operand, [15:12] most significant
//   OpCode     : operator key code accompanying Operand
//   EntryValue : live BCD entry for the display
//   DigitCount : digits currently entered (0..4)
//   Overflow   : sticky, a fifth digit was attempted
module key_entry_accumulator #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  BCDKey,
    input  logic        KeyRead,
    input  logic        OpReady,
    output logic        OpValid,
    output logic [15:0] Operand,
    output logic [3:0]  OpCode,
    output logic [15:0] EntryValue,
    output logic [2:0]  DigitCount,
    output logic        Overflow
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // With a single required sample, the first sample both starts and
    // completes the debounce, so PRESS/RELEASE are bypassed.
    localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      cap_code, cap_nxt;
    logic            accept_q, accept_nxt;
    logic            kr_q;
    logic [3:0]      key_q;

    // Input register stage
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            kr_q  <= 1'b0;
            key_q <= 4'h0;
        end else begin
            kr_q  <= KeyRead;
            key_q <= BCDKey;
        end
    end

    // Debounce state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cap_code <= 4'h0;
            accept_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cap_code <= cap_nxt;
            accept_q <= accept_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cap_nxt    = cap_code;
        accept_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (kr_q) begin
                    cap_nxt = key_q;
                    cnt_nxt = CNT_ONE;
                    if (SINGLE_SAMPLE) begin
                        state_nxt  = S_HELD;
                        accept_nxt = 1'b1;
                    end else begin
                        state_nxt = S_PRESS;
                    end
                end
            end
            S_PRESS: begin
                if (!kr_q || (key_q != cap_code)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nxt  = S_HELD;
                        accept_nxt = 1'b1;
                    end
                end
            end
            S_HELD: begin
                // Code changes while held are deliberately ignored.
                if (!kr_q) begin
                    if (SINGLE_SAMPLE) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_RELEASE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_RELEASE: begin
                if (kr_q) begin
                    state_nxt = S_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Entry and handshake stage. cap_code stays stable through HELD, so it
    // is the accepted key while accept_q is high.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            OpValid    <= 1'b0;
            Operand    <= 16'h0000;
            OpCode     <= 4'h0;
            EntryValue <= 16'h0000;
            DigitCount <= 3'd0;
            Overflow   <= 1'b0;
        end else begin
            if (OpValid && OpReady) begin
                OpValid <= 1'b0;
            end
            // A key accepted while a pair is pending (even one completing
            // this cycle) is consumed and dropped.
            if (accept_q && !OpValid) begin
                if (cap_code <= 4'h9) begin
                    if (DigitCount < 3'd4) begin
                        EntryValue <= {EntryValue[11:0], cap_code};
                        DigitCount <= DigitCount + 3'd1;
                    end else begin
                        Overflow <= 1'b1;
                    end
                end else begin
                    case (cap_code)
                        4'hD: begin
                            if (DigitCount != 3'd0) begin
                                EntryValue <= EntryValue >> 4;
                                DigitCount <= DigitCount - 3'd1;
                            end
                        end
                        4'hE: begin
                            EntryValue <= 16'h0000;
                            DigitCount <= 3'd0;
                            Overflow   <= 1'b0;
                        end
                        default: begin
                            Operand    <= EntryValue;
                            OpCode     <= cap_code;
                            OpValid    <= 1'b1;
                            EntryValue <= 16'h0000;
                            DigitCount <= 3'd0;
                            Overflow   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
